// File: rtl/ram_pkg.sv
// ram_pkg: read-during-write mode constants and mode validation for singleport_ram
package ram_pkg;
  typedef logic [8*11-1:0] mode_t;
  localparam mode_t MODE_WRITE_FIRST = "Write_first";
  localparam mode_t MODE_READ_FIRST  = "Read_first";
  localparam mode_t MODE_NO_CHANGE   = "No_change";
  function automatic logic mode_ok(input mode_t m);
    return (m == MODE_WRITE_FIRST) || (m == MODE_READ_FIRST) || (m == MODE_NO_CHANGE);
  endfunction
endpackage

// File: rtl/ram_array.sv
// ram_array: DEPTH x WIDTH storage, synchronous write, combinational read, never reset
module ram_array #(
  parameter int DEPTH = 64,
  parameter int WIDTH = 8,
  parameter int ADDR_WIDTH = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [WIDTH-1:0]      wdata,
  output logic [WIDTH-1:0]      rdata
);
  logic [WIDTH-1:0] mem [0:DEPTH-1];
  always_ff @(posedge clk)
    if (we) mem[addr] <= wdata;
  assign rdata = mem[addr];
endmodule

// File: rtl/singleport_ram.sv
// singleport_ram: single-port RAM with registered output and elaboration-time read-during-write mode
module singleport_ram import ram_pkg::*; #(
  parameter int    DEPTH = 64,
  parameter int    WIDTH = 8,
  parameter mode_t MODE  = MODE_NO_CHANGE,
  localparam int   ADDR_WIDTH = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [WIDTH-1:0]      data_in,
  output logic [WIDTH-1:0]      data_out
);
  logic             in_range;
  logic [WIDTH-1:0] rd_data, rd_val, wr_val, data_out_d, data_out_q;

  if (!mode_ok(MODE)) begin : g_bad_mode
    $error("singleport_ram: illegal MODE");
  end

  if (DEPTH == 2**ADDR_WIDTH) begin : g_full
    assign in_range = 1'b1;
  end else begin : g_partial
    assign in_range = addr < ADDR_WIDTH'(DEPTH);
  end

  // rst_n gates the write enable so an edge during reset never writes
  ram_array #(.DEPTH(DEPTH), .WIDTH(WIDTH), .ADDR_WIDTH(ADDR_WIDTH)) u_array (
    .clk   (clk),
    .we    (wr_en & rst_n & in_range),
    .addr  (addr),
    .wdata (data_in),
    .rdata (rd_data)
  );

  assign rd_val = in_range ? rd_data : '0;

  if (MODE == MODE_WRITE_FIRST) begin : g_write_first
    assign wr_val = data_in;
  end else if (MODE == MODE_READ_FIRST) begin : g_read_first
    assign wr_val = rd_val;
  end else begin : g_no_change
    assign wr_val = data_out_q;
  end

  always_comb data_out_d = wr_en ? wr_val : rd_val;

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) data_out_q <= '0;
    else        data_out_q <= data_out_d;

  assign data_out = data_out_q;
endmodule

// File: tb/tb_singleport_ram.sv
// tb_singleport_ram: directed table-driven check of all three modes plus a non-power-of-2 depth
module tb_singleport_ram;
  logic       clk, rst_n, wr_en;
  logic [5:0] addr;
  logic [7:0] data_in;
  logic [7:0] q_nc, q_wf, q_rf, q_48;
  int total = 0, bad = 0;

  singleport_ram #(64, 8, "No_change")   u_nc (.clk(clk), .rst_n(rst_n), .wr_en(wr_en), .addr(addr), .data_in(data_in), .data_out(q_nc));
  singleport_ram #(64, 8, "Write_first") u_wf (.clk(clk), .rst_n(rst_n), .wr_en(wr_en), .addr(addr), .data_in(data_in), .data_out(q_wf));
  singleport_ram #(64, 8, "Read_first")  u_rf (.clk(clk), .rst_n(rst_n), .wr_en(wr_en), .addr(addr), .data_in(data_in), .data_out(q_rf));
  singleport_ram #(48, 8, "No_change")   u_48 (.clk(clk), .rst_n(rst_n), .wr_en(wr_en), .addr(addr), .data_in(data_in), .data_out(q_48));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic       wr;
    logic [5:0] a;
    logic [7:0] d;
    logic [7:0] nc, wf, rf, d48;
  } vec_t;
  vec_t v [18];

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic chk_all(input string nm, input logic [7:0] nc, input logic [7:0] wf, input logic [7:0] rf, input logic [7:0] d48);
    chk({nm, " nc"}, q_nc, nc);
    chk({nm, " wf"}, q_wf, wf);
    chk({nm, " rf"}, q_rf, rf);
    chk({nm, " d48"}, q_48, d48);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    v[0]  = '{1'b0, 6'd37, 8'h00, 8'h25, 8'h25, 8'h25, 8'h25};
    v[1]  = '{1'b1, 6'd12, 8'hA5, 8'h25, 8'hA5, 8'h0C, 8'h25};
    v[2]  = '{1'b0, 6'd12, 8'h00, 8'hA5, 8'hA5, 8'hA5, 8'hA5};
    v[3]  = '{1'b1, 6'd5,  8'h3C, 8'hA5, 8'h3C, 8'h05, 8'hA5};
    v[4]  = '{1'b1, 6'd6,  8'h3C, 8'hA5, 8'h3C, 8'h06, 8'hA5};
    v[5]  = '{1'b0, 6'd6,  8'h00, 8'h3C, 8'h3C, 8'h3C, 8'h3C};
    v[6]  = '{1'b0, 6'd5,  8'h00, 8'h3C, 8'h3C, 8'h3C, 8'h3C};
    v[7]  = '{1'b1, 6'd9,  8'h81, 8'h3C, 8'h81, 8'h09, 8'h3C};
    v[8]  = '{1'b1, 6'd40, 8'h0D, 8'h3C, 8'h0D, 8'h28, 8'h3C};
    v[9]  = '{1'b1, 6'd9,  8'h65, 8'h3C, 8'h65, 8'h81, 8'h3C};
    v[10] = '{1'b0, 6'd9,  8'h00, 8'h65, 8'h65, 8'h65, 8'h65};
    v[11] = '{1'b0, 6'd40, 8'h00, 8'h0D, 8'h0D, 8'h0D, 8'h0D};
    v[12] = '{1'b1, 6'd50, 8'hFF, 8'h0D, 8'hFF, 8'h32, 8'h0D};
    v[13] = '{1'b0, 6'd50, 8'h00, 8'hFF, 8'hFF, 8'hFF, 8'h00};
    v[14] = '{1'b0, 6'd47, 8'h00, 8'h2F, 8'h2F, 8'h2F, 8'h2F};
    v[15] = '{1'b1, 6'd0,  8'h5A, 8'h2F, 8'h5A, 8'h00, 8'h2F};
    v[16] = '{1'b0, 6'd63, 8'h00, 8'h3F, 8'h3F, 8'h3F, 8'h00};
    v[17] = '{1'b0, 6'd0,  8'h00, 8'h5A, 8'h5A, 8'h5A, 8'h5A};

    rst_n = 1'b0; wr_en = 1'b0; addr = '0; data_in = '0;
    #1;
    chk_all("reset", 8'h00, 8'h00, 8'h00, 8'h00);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 64; i++) begin
      wr_en = 1'b1; addr = 6'(i); data_in = 8'(i);
      @(posedge clk); #1;
      chk("preload nc", q_nc, 8'h00);
      chk("preload d48", q_48, 8'h00);
      if (i > 0) chk("preload wf", q_wf, 8'(i));
      @(negedge clk);
    end

    for (int i = 0; i < 18; i++) begin
      wr_en = v[i].wr; addr = v[i].a; data_in = v[i].d;
      @(posedge clk); #1;
      chk_all($sformatf("vec%0d", i), v[i].nc, v[i].wf, v[i].rf, v[i].d48);
      @(negedge clk);
    end

    wr_en = 1'b0; addr = 6'd12;
    @(posedge clk); #1;
    chk_all("pre-reset rd12", 8'hA5, 8'hA5, 8'hA5, 8'hA5);
    @(negedge clk); #2;
    rst_n = 1'b0;
    #1;
    chk_all("async reset", 8'h00, 8'h00, 8'h00, 8'h00);
    wr_en = 1'b1; addr = 6'd3; data_in = 8'h77;
    @(posedge clk); #1;
    chk_all("write in reset", 8'h00, 8'h00, 8'h00, 8'h00);
    @(negedge clk);
    rst_n = 1'b1; wr_en = 1'b0; addr = 6'd3;
    @(posedge clk); #1;
    chk_all("rd3 after reset", 8'h03, 8'h03, 8'h03, 8'h03);
    @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
